hazard_stall_ctrl: RTL

Pipeline hazard and stall controller for the 5-stage core. It produces the write-enable and flush controls for the IF/ID pipeline register, the PC-write enable, and the ID/EX bubble. It covers three cases: load-use hazards, in-order access to the multi-cycle multiply/divide unit (MDU), and taken-branch flushes resolved in ID. It also tracks MDU occupancy and keeps stall and flush performance counters.

---
 rtl/hazard_stall_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Hazard and stall controller for the 5-stage core. It decides when the front
// end (PC and IF/ID) must hold, when ID/EX receives a bubble, and when IF/ID is
// flushed by a taken branch or jump resolved in ID. It also tracks occupancy of
// the multi-cycle multiply/divide unit (MDU) and keeps two performance counters.
//
// Parameters
//   MULT_LAT       busy cycles after a multiply issues (>= 1)
//   DIV_LAT        busy cycles after a divide issues (>= 1)
//
// Ports
//   clk            pipeline clock, all state updates on the rising edge
//   reset          asynchronous, active-high reset
//   ID_rs/ID_rt    source register fields of the instruction in ID
//   ID_uses_rs/rt  the ID instruction actually reads rs / rt
//   EX_MemRead     the instruction in EX is a load
//   EX_rt          destination register of that load
//   ID_mdu_start   the ID instruction is mult/multu/div/divu
//   ID_mdu_div     qualifies ID_mdu_start: 1 = divide, 0 = multiply
//   ID_hilo_access the ID instruction touches HI/LO (includes MDU starts)
//   ID_branch_taken branch/jump in ID resolved taken
//   PCWrite        PC update enable
//   IF_IDWrite     IF/ID register load enable
//   IF_Flush       IF/ID register clear (wins over IF_IDWrite at the register)
//   ID_EX_Bubble   zero the ID/EX control fields
//   mdu_busy       MDU occupied
//   stall_cycles   number of stalled cycles, wraps modulo 2^32
//   flush_count    number of issued flushes, wraps modulo 2^32
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rs,
    input  logic        ID_uses_rt,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rt,
    input  logic        ID_mdu_start,
    input  logic        ID_mdu_div,
    input  logic        ID_hilo_access,
    input  logic        ID_branch_taken,
    output logic        PCWrite,
    output logic        IF_IDWrite,
    output logic        IF_Flush,
    output logic        ID_EX_Bubble,
    output logic        mdu_busy,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t       state;
    mdu_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic load_use;
    logic mdu_stall;
    logic stall;
    logic flush;

    // Hazard detection. $0 is hardwired, so a load "into" it never hazards.
    always_comb begin
        load_use  = EX_MemRead && (EX_rt != 5'd0) &&
                    ((ID_uses_rs && (ID_rs == EX_rt)) ||
                     (ID_uses_rt && (ID_rt == EX_rt)));
        mdu_stall = (state == BUSY) && ID_hilo_access;
        stall     = load_use || mdu_stall;
        // A stalled branch stays in ID and is re-evaluated, so no flush yet.
        flush     = ID_branch_taken && !stall;
    end

    // MDU state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // MDU next-state logic. A start while BUSY is always a hilo access and is
    // therefore stalled, so BUSY never reloads the counter.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (ID_mdu_start && !stall) begin
                    state_next = BUSY;
                    cnt_next   = ID_mdu_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic. Every pipeline control is held inactive while reset is high.
    always_comb begin
        mdu_busy     = (state == BUSY);
        PCWrite      = 1'b0;
        IF_IDWrite   = 1'b0;
        IF_Flush     = 1'b0;
        ID_EX_Bubble = 1'b0;
        if (!reset) begin
            PCWrite      = !stall;
            IF_IDWrite   = !stall;
            IF_Flush     = flush;
            ID_EX_Bubble = stall;
        end
    end

    // Performance counters, free-running and wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end

endmodule
